// File: rtl/dual_issue_unit_pkg.sv
// Shared definitions for the dual-issue stage: register-file geometry, PC width,
// the x0 address and the registered issue-slot record.
package dual_issue_unit_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned NUM_REGS   = 1 << REG_ADDR_W;

  localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  rd_write;
    logic                  mem;
    logic [XLEN-1:0]       pc;
  } issue_slot_t;

  // x0 writes are architecturally discarded, so they never create a dependency.
  function automatic logic rd_live(input logic wr, input logic [REG_ADDR_W-1:0] rd);
    return wr && (rd != REG_X0);
  endfunction

endpackage

// File: rtl/dual_issue_unit_issue_scoreboard.sv
// Pending-write scoreboard, one bit per architectural register.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   set_a/b, set_a/b_addr      mark a register as having a write in flight
//   clr_a/b, clr_a/b_addr      writeback completion clears
//   flush_clr                  mask of bits to drop on a squash
//   lookup_addr, lookup_pend   six combinational read lookups
module issue_scoreboard
  import dual_issue_unit_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       set_a,
  input  logic [REG_ADDR_W-1:0]      set_a_addr,
  input  logic                       set_b,
  input  logic [REG_ADDR_W-1:0]      set_b_addr,
  input  logic                       clr_a,
  input  logic [REG_ADDR_W-1:0]      clr_a_addr,
  input  logic                       clr_b,
  input  logic [REG_ADDR_W-1:0]      clr_b_addr,
  input  logic [NUM_REGS-1:0]        flush_clr,
  input  logic [5:0][REG_ADDR_W-1:0] lookup_addr,
  output logic [5:0]                 lookup_pend
);

  logic [NUM_REGS-1:0] pend_q, pend_d, set_mask, clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = flush_clr;
    if (clr_a) clr_mask[clr_a_addr] = 1'b1;
    if (clr_b) clr_mask[clr_b_addr] = 1'b1;
    if (set_a) set_mask[set_a_addr] = 1'b1;
    if (set_b) set_mask[set_b_addr] = 1'b1;
    // Set applied after clear: a new writer wins over an old writeback.
    pend_d         = (pend_q & ~clr_mask) | set_mask;
    pend_d[REG_X0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  always_comb begin
    for (int i = 0; i < 6; i++) lookup_pend[i] = pend_q[lookup_addr[i]];
  end

endmodule

// File: rtl/dual_issue_unit.sv
// Two-lane in-order issue stage in front of the dual-port register file.
// Decides per cycle: issue A+B, A only, or nothing; drives register-file read
// addresses; registers issued control to line up with registered read data.
// Ports: clock_i/reset_n_i; A_*/B_* decoded slot fields; A/B_take_o consume
// strobes; A/B_rs*_addr_o read addresses; A/B_wb_* writeback; stall_i, flush_i;
// A/B_iss_* registered issue outputs.
// Optional: DUAL_ISSUE_STATS_EN adds saturating stat_dual_o/stat_single_o/stat_hazard_o.
// Slot record widths follow the package defaults.
module dual_issue_unit #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned XLEN       = 32,
  parameter int unsigned STAT_W     = 32
) (
  input  logic                  clock_i,
  input  logic                  reset_n_i,
  input  logic                  A_valid_i,
  input  logic                  B_valid_i,
  input  logic [REG_ADDR_W-1:0] A_rs1_i,
  input  logic [REG_ADDR_W-1:0] A_rs2_i,
  input  logic [REG_ADDR_W-1:0] A_rd_i,
  input  logic [REG_ADDR_W-1:0] B_rs1_i,
  input  logic [REG_ADDR_W-1:0] B_rs2_i,
  input  logic [REG_ADDR_W-1:0] B_rd_i,
  input  logic                  A_rd_write_i,
  input  logic                  B_rd_write_i,
  input  logic                  A_mem_i,
  input  logic                  B_mem_i,
  input  logic [XLEN-1:0]       A_pc_i,
  input  logic [XLEN-1:0]       B_pc_i,
  output logic                  A_take_o,
  output logic                  B_take_o,
  output logic [REG_ADDR_W-1:0] A_rs1_addr_o,
  output logic [REG_ADDR_W-1:0] A_rs2_addr_o,
  output logic [REG_ADDR_W-1:0] B_rs1_addr_o,
  output logic [REG_ADDR_W-1:0] B_rs2_addr_o,
  input  logic [REG_ADDR_W-1:0] A_wb_rd_i,
  input  logic [REG_ADDR_W-1:0] B_wb_rd_i,
  input  logic                  A_wb_write_i,
  input  logic                  B_wb_write_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  output logic                  A_iss_valid_o,
  output logic                  B_iss_valid_o,
  output logic [REG_ADDR_W-1:0] A_iss_rd_o,
  output logic [REG_ADDR_W-1:0] B_iss_rd_o,
  output logic                  A_iss_rd_write_o,
  output logic                  B_iss_rd_write_o,
  output logic                  A_iss_mem_o,
  output logic                  B_iss_mem_o,
  output logic [XLEN-1:0]       A_iss_pc_o,
  output logic [XLEN-1:0]       B_iss_pc_o
`ifdef DUAL_ISSUE_STATS_EN
  ,
  output logic [STAT_W-1:0]     stat_dual_o,
  output logic [STAT_W-1:0]     stat_single_o,
  output logic [STAT_W-1:0]     stat_hazard_o
`endif
);

  import dual_issue_unit_pkg::*;

  if (STAT_W < 1) begin : g_stat_w_invalid
  end

  logic                  a_live, b_live, issue_a, issue_b;
  logic [5:0][REG_ADDR_W-1:0] lookup_addr;
  logic [5:0]            pend;
  logic [NUM_REGS-1:0]   flush_clr;
  issue_slot_t           a_q, a_d, b_q, b_d;

  assign A_rs1_addr_o = A_rs1_i;
  assign A_rs2_addr_o = A_rs2_i;
  assign B_rs1_addr_o = B_rs1_i;
  assign B_rs2_addr_o = B_rs2_i;

  assign lookup_addr = {B_rd_i, B_rs2_i, B_rs1_i, A_rd_i, A_rs2_i, A_rs1_i};

  assign a_live = rd_live(A_rd_write_i, A_rd_i);
  assign b_live = rd_live(B_rd_write_i, B_rd_i);

  assign issue_a = A_valid_i && !flush_i && !stall_i && !pend[0] && !pend[1] &&
                   !(a_live && pend[2]);

  // B is younger: it must not depend on, or race, A's write inside the pair.
  assign issue_b = issue_a && B_valid_i && !pend[3] && !pend[4] && !(b_live && pend[5]) &&
                   !(a_live && ((B_rs1_i == A_rd_i) || (B_rs2_i == A_rd_i))) &&
                   !(a_live && b_live && (B_rd_i == A_rd_i)) &&
                   !(A_mem_i && B_mem_i);

  assign A_take_o = issue_a;
  assign B_take_o = issue_b;

  // Squashed entries will never write back, so release their reservations.
  always_comb begin
    flush_clr = '0;
    if (flush_i) begin
      if (a_q.valid && rd_live(a_q.rd_write, a_q.rd)) flush_clr[a_q.rd] = 1'b1;
      if (b_q.valid && rd_live(b_q.rd_write, b_q.rd)) flush_clr[b_q.rd] = 1'b1;
    end
  end

  issue_scoreboard u_scoreboard (
    .clk         (clock_i),
    .rst_n       (reset_n_i),
    .set_a       (issue_a && a_live),
    .set_a_addr  (A_rd_i),
    .set_b       (issue_b && b_live),
    .set_b_addr  (B_rd_i),
    .clr_a       (A_wb_write_i),
    .clr_a_addr  (A_wb_rd_i),
    .clr_b       (B_wb_write_i),
    .clr_b_addr  (B_wb_rd_i),
    .flush_clr   (flush_clr),
    .lookup_addr (lookup_addr),
    .lookup_pend (pend)
  );

  // Flush falls through to a load with valid=0 since nothing issues under flush.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (!(stall_i && !flush_i)) begin
      a_d = '{valid: issue_a, rd: A_rd_i, rd_write: A_rd_write_i, mem: A_mem_i, pc: A_pc_i};
      b_d = '{valid: issue_b, rd: B_rd_i, rd_write: B_rd_write_i, mem: B_mem_i, pc: B_pc_i};
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  assign A_iss_valid_o    = a_q.valid;
  assign A_iss_rd_o       = a_q.rd;
  assign A_iss_rd_write_o = a_q.rd_write;
  assign A_iss_mem_o      = a_q.mem;
  assign A_iss_pc_o       = a_q.pc;
  assign B_iss_valid_o    = b_q.valid;
  assign B_iss_rd_o       = b_q.rd;
  assign B_iss_rd_write_o = b_q.rd_write;
  assign B_iss_mem_o      = b_q.mem;
  assign B_iss_pc_o       = b_q.pc;

`ifdef DUAL_ISSUE_STATS_EN
  logic              hazard;
  logic [STAT_W-1:0] dual_q, single_q, hazard_q;

  assign hazard = A_valid_i && !stall_i && !flush_i && !issue_a;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      dual_q   <= '0;
      single_q <= '0;
      hazard_q <= '0;
    end else begin
      if (issue_a && issue_b && (dual_q != '1))    dual_q   <= dual_q + STAT_W'(1);
      if (issue_a && !issue_b && (single_q != '1)) single_q <= single_q + STAT_W'(1);
      if (hazard && (hazard_q != '1))              hazard_q <= hazard_q + STAT_W'(1);
    end
  end

  assign stat_dual_o   = dual_q;
  assign stat_single_o = single_q;
  assign stat_hazard_o = hazard_q;
`endif

endmodule
